// File: rtl/ultrasound_scan_scheduler.sv
// Shares one median-of-3 ranging engine across up to 6 sensors; one enable/done transaction per enabled sensor.
// Results latch once per scan in REPORT; the engine is never re-enabled before meas_done or the timeout.
module ultrasound_scan_scheduler #(
    parameter int NUM_SENSORS    = 6,
    parameter int TIMEOUT_CYCLES = 5_000_000,
    parameter int GUARD_CYCLES   = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic        continuous,
    input  logic [5:0]  sensor_mask,
    output logic        meas_enable,
    output logic [3:0]  meas_sensor,
    input  logic        meas_done,
    input  logic [7:0]  meas_distance,
    output logic [47:0] distances,
    output logic [5:0]  valid_mask,
    output logic [3:0]  best_sensor,
    output logic [7:0]  best_distance,
    output logic        any_valid,
    output logic        scan_done,
    output logic        busy,
    output logic [3:0]  state
);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_SELECT = 4'd1,
        S_ISSUE  = 4'd2,
        S_GUARD  = 4'd3,
        S_WAIT   = 4'd4,
        S_STORE  = 4'd5,
        S_REPORT = 4'd6
    } state_t;

    localparam logic [5:0]  SENSOR_BITS = 6'((7'd1 << NUM_SENSORS) - 7'd1);
    localparam logic [2:0]  IDX_END     = 3'(NUM_SENSORS);
    localparam logic [23:0] LAST_TICK   = 24'(TIMEOUT_CYCLES - 1);
    localparam logic [23:0] GUARD_LAST  = 24'(GUARD_CYCLES - 1);

    state_t      st;
    logic [5:0]  mask_q;
    logic [2:0]  idx;
    logic [23:0] timer;
    logic [7:0]  scr_dist [0:5];
    logic [5:0]  scr_vld;
    logic [3:0]  scr_best_idx;
    logic [7:0]  scr_best_dist;
    logic [7:0]  cap_dist;
    logic        cap_vld;
    logic        begin_scan;

    assign state = st;
    assign busy  = (st != S_IDLE);

    // A new scan starts either from IDLE on start or back-to-back from REPORT in continuous mode.
    assign begin_scan = ((st == S_IDLE) && start) || ((st == S_REPORT) && continuous);

    always_ff @(posedge clock) begin
        if (reset) begin
            st            <= S_IDLE;
            meas_enable   <= 1'b0;
            meas_sensor   <= 4'd0;
            distances     <= '1;
            valid_mask    <= 6'd0;
            best_sensor   <= 4'hF;
            best_distance <= 8'hFF;
            any_valid     <= 1'b0;
            scan_done     <= 1'b0;
            timer         <= 24'd0;
            mask_q        <= 6'd0;
            idx           <= 3'd0;
            scr_vld       <= 6'd0;
            scr_best_idx  <= 4'hF;
            scr_best_dist <= 8'hFF;
            cap_dist      <= 8'hFF;
            cap_vld       <= 1'b0;
            for (int i = 0; i < 6; i++) scr_dist[i] <= 8'hFF;
        end else begin
            meas_enable <= 1'b0;
            scan_done   <= 1'b0;
            case (st)
                S_IDLE: begin
                    if (start) st <= S_SELECT;
                end
                S_SELECT: begin
                    if (idx >= IDX_END) begin
                        st <= S_REPORT;
                    end else if (mask_q[idx]) begin
                        meas_sensor <= {1'b0, idx};
                        meas_enable <= 1'b1;
                        st          <= S_ISSUE;
                    end else begin
                        idx <= idx + 3'd1;
                    end
                end
                S_ISSUE: begin
                    timer <= 24'd0;
                    st    <= S_GUARD;
                end
                S_GUARD: begin
                    // meas_done may still be high from the previous engine run; ignore it here.
                    timer <= timer + 24'd1;
                    if (timer == GUARD_LAST) st <= S_WAIT;
                end
                S_WAIT: begin
                    timer <= timer + 24'd1;
                    if (meas_done) begin
                        cap_dist <= meas_distance;
                        cap_vld  <= 1'b1;
                        st       <= S_STORE;
                    end else if (timer == LAST_TICK) begin
                        cap_dist <= 8'hFF;
                        cap_vld  <= 1'b0;
                        st       <= S_STORE;
                    end
                end
                S_STORE: begin
                    scr_dist[idx] <= cap_dist;
                    scr_vld[idx]  <= cap_vld;
                    // Strict compare keeps the lowest index on ties.
                    if (cap_vld && ((scr_best_idx == 4'hF) || (cap_dist < scr_best_dist))) begin
                        scr_best_idx  <= {1'b0, idx};
                        scr_best_dist <= cap_dist;
                    end
                    idx <= idx + 3'd1;
                    st  <= S_SELECT;
                end
                S_REPORT: begin
                    for (int i = 0; i < 6; i++) distances[8*i +: 8] <= scr_dist[i];
                    valid_mask    <= scr_vld;
                    best_sensor   <= scr_best_idx;
                    best_distance <= scr_best_dist;
                    any_valid     <= |scr_vld;
                    scan_done     <= 1'b1;
                    st            <= continuous ? S_SELECT : S_IDLE;
                end
                default: st <= S_IDLE;
            endcase

            if (begin_scan) begin
                mask_q        <= sensor_mask & SENSOR_BITS;
                idx           <= 3'd0;
                scr_vld       <= 6'd0;
                scr_best_idx  <= 4'hF;
                scr_best_dist <= 8'hFF;
                for (int i = 0; i < 6; i++) scr_dist[i] <= 8'hFF;
            end
        end
    end

endmodule

// File: tb/tb_ultrasound_scan_scheduler.sv
// Directed bench for ultrasound_scan_scheduler: a behavioural engine checks each enable against a
// queue of expected sensors, and each scan's results are compared against a model of the stimulus.
module tb_ultrasound_scan_scheduler;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic        continuous;
    logic [5:0]  sensor_mask;
    logic        meas_enable;
    logic [3:0]  meas_sensor;
    logic        meas_done;
    logic [7:0]  meas_distance;
    logic [47:0] distances;
    logic [5:0]  valid_mask;
    logic [3:0]  best_sensor;
    logic [7:0]  best_distance;
    logic        any_valid;
    logic        scan_done;
    logic        busy;
    logic [3:0]  state;

    ultrasound_scan_scheduler #(
        .NUM_SENSORS(6),
        .TIMEOUT_CYCLES(100),
        .GUARD_CYCLES(2)
    ) dut (
        .clock(clock),
        .reset(reset),
        .start(start),
        .continuous(continuous),
        .sensor_mask(sensor_mask),
        .meas_enable(meas_enable),
        .meas_sensor(meas_sensor),
        .meas_done(meas_done),
        .meas_distance(meas_distance),
        .distances(distances),
        .valid_mask(valid_mask),
        .best_sensor(best_sensor),
        .best_distance(best_distance),
        .any_valid(any_valid),
        .scan_done(scan_done),
        .busy(busy),
        .state(state)
    );

    always #5 clock = ~clock;

    typedef struct {
        int         s;
        int         stale;
        int         dly;
        bit         give;
        logic [7:0] val;
    } resp_t;

    resp_t      resp_q[$];
    int         tests = 0;
    int         fails = 0;
    int         done_cnt = 0;
    int         en_cnt = 0;
    int         en_double = 0;
    int         s3_wait = 0;
    int         done0;
    bit         stale_pre = 1'b0;
    logic [7:0] exp_dist [6];
    bit         exp_vld [6];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_resp(input int s, input logic [7:0] v, input bit give = 1'b1,
                             input int stale = 0, input int dly = 4);
        resp_t r;
        r.s = s; r.val = v; r.give = give; r.stale = stale; r.dly = dly;
        resp_q.push_back(r);
    endtask

    task automatic expect_meas(input int s, input logic [7:0] v, input bit give = 1'b1,
                               input int stale = 0, input int dly = 4);
        push_resp(s, v, give, stale, dly);
        exp_dist[s] = give ? v : 8'hFF;
        exp_vld[s]  = give;
    endtask

    task automatic clear_model();
        for (int i = 0; i < 6; i++) begin
            exp_dist[i] = 8'hFF;
            exp_vld[i]  = 1'b0;
        end
    endtask

    task automatic do_start(input logic [5:0] mask);
        done0       = done_cnt;
        sensor_mask = mask;
        start       = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
    endtask

    task automatic wait_check(input string tag, input bit expect_idle);
        int         n;
        logic [47:0] ed;
        logic [5:0]  ev;
        logic [3:0]  eb_s;
        logic [7:0]  eb_d;
        n = 0;
        while (scan_done !== 1'b1 && n < 3000) begin
            @(posedge clock); #1;
            n++;
        end
        check({tag, "_scan_done_seen"}, scan_done, 1'b1);
        ed = '1; ev = '0; eb_s = 4'hF; eb_d = 8'hFF;
        for (int i = 0; i < 6; i++) begin
            ed[8*i +: 8] = exp_dist[i];
            if (exp_vld[i]) begin
                ev[i] = 1'b1;
                if (eb_s == 4'hF || exp_dist[i] < eb_d) begin
                    eb_s = 4'(i);
                    eb_d = exp_dist[i];
                end
            end
        end
        check({tag, "_distances"}, distances, ed);
        check({tag, "_valid_mask"}, valid_mask, ev);
        check({tag, "_best_sensor"}, best_sensor, eb_s);
        check({tag, "_best_distance"}, best_distance, eb_d);
        check({tag, "_any_valid"}, any_valid, |ev);
        repeat (3) begin @(posedge clock); #1; end
        check({tag, "_done_pulses"}, done_cnt - done0, 1);
        if (expect_idle) check({tag, "_idle_after"}, state, 4'd0);
    endtask

    // Behavioural measurement engine.
    initial begin : engine
        resp_t r;
        meas_done = 1'b0;
        meas_distance = 8'd0;
        forever begin
            @(posedge clock); #1;
            if (stale_pre) begin
                meas_done = 1'b1;
                meas_distance = 8'd99;
            end
            if (meas_enable === 1'b1) begin
                check("enable_expected", resp_q.size() != 0, 1'b1);
                if (resp_q.size() != 0) begin
                    r = resp_q.pop_front();
                    check("meas_sensor_order", meas_sensor, r.s);
                    repeat (r.stale) begin @(posedge clock); #1; end
                    meas_done = 1'b0;
                    if (r.give) begin
                        repeat (r.dly) begin @(posedge clock); #1; end
                        meas_done = 1'b1;
                        meas_distance = r.val;
                        @(posedge clock); #1;
                        meas_done = 1'b0;
                    end
                end
            end
        end
    end

    initial begin : monitor
        logic prev_en;
        prev_en = 1'b0;
        forever begin
            @(posedge clock); #1;
            if (scan_done === 1'b1) done_cnt++;
            if (meas_enable === 1'b1) begin
                en_cnt++;
                if (prev_en) en_double++;
            end
            prev_en = meas_enable;
            if ((state == 4'd3 || state == 4'd4) && meas_sensor == 4'd3) s3_wait++;
        end
    end

    initial begin : main
        int en0;
        int w0;
        int n;
        reset = 1'b1; start = 1'b0; continuous = 1'b0; sensor_mask = 6'd0;
        repeat (3) @(posedge clock);
        #1;
        check("rst_state", state, 4'd0);
        check("rst_meas_enable", meas_enable, 1'b0);
        check("rst_meas_sensor", meas_sensor, 4'd0);
        check("rst_distances", distances, 48'hFFFF_FFFF_FFFF);
        check("rst_valid_mask", valid_mask, 6'd0);
        check("rst_best_sensor", best_sensor, 4'hF);
        check("rst_best_distance", best_distance, 8'hFF);
        check("rst_any_valid", any_valid, 1'b0);
        check("rst_scan_done", scan_done, 1'b0);
        check("rst_busy", busy, 1'b0);
        reset = 1'b0;
        @(posedge clock); #1;

        // Full mask with a tie at 25.
        clear_model();
        expect_meas(0, 8'd40); expect_meas(1, 8'd25); expect_meas(2, 8'd90);
        expect_meas(3, 8'd25); expect_meas(4, 8'd60); expect_meas(5, 8'd70);
        en0 = en_cnt;
        do_start(6'h3F);
        check("t1_busy", busy, 1'b1);
        wait_check("t1", 1'b1);
        check("t1_best_is_1", best_sensor, 4'd1);
        check("t1_best_is_25", best_distance, 8'd25);
        check("t1_enables", en_cnt - en0, 6);

        // Sparse mask.
        clear_model();
        expect_meas(0, 8'd30); expect_meas(2, 8'd12);
        en0 = en_cnt;
        do_start(6'b000101);
        wait_check("t2", 1'b1);
        check("t2_enables", en_cnt - en0, 2);

        // Stale done held across ISSUE/GUARD, real result 10 cycles later.
        clear_model();
        expect_meas(0, 8'd50, 1'b1, 3, 10);
        stale_pre = 1'b1;
        @(posedge clock); #1;
        do_start(6'b000001);
        stale_pre = 1'b0;
        wait_check("t3", 1'b1);

        // Sensor 3 times out, sensor 4 still measured.
        clear_model();
        expect_meas(3, 8'd0, 1'b0); expect_meas(4, 8'd7);
        w0 = s3_wait;
        do_start(6'b011000);
        wait_check("t4", 1'b1);
        check("t4_timeout_cycles", s3_wait - w0, 100);

        // Empty mask, then all timeouts.
        clear_model();
        en0 = en_cnt;
        do_start(6'b000000);
        wait_check("t5a", 1'b1);
        check("t5a_no_enable", en_cnt - en0, 0);
        clear_model();
        expect_meas(1, 8'd0, 1'b0); expect_meas(5, 8'd0, 1'b0);
        do_start(6'b100010);
        wait_check("t5b", 1'b1);

        // Continuous mode, reset during WAIT of the second scan.
        clear_model();
        expect_meas(0, 8'd20); expect_meas(1, 8'd10);
        push_resp(0, 8'd30); push_resp(1, 8'd0, 1'b0);
        continuous = 1'b1;
        do_start(6'b000011);
        wait_check("t6_scan1", 1'b0);
        n = 0;
        while (!(state == 4'd4 && meas_sensor == 4'd1) && n < 500) begin
            @(posedge clock); #1;
            n++;
        end
        check("t6_reached_wait", (state == 4'd4 && meas_sensor == 4'd1), 1'b1);
        w0 = done_cnt;
        reset = 1'b1; continuous = 1'b0;
        @(posedge clock); #1;
        check("t6_rst_state", state, 4'd0);
        check("t6_rst_enable", meas_enable, 1'b0);
        check("t6_rst_busy", busy, 1'b0);
        check("t6_rst_distances", distances, 48'hFFFF_FFFF_FFFF);
        check("t6_rst_valid_mask", valid_mask, 6'd0);
        check("t6_rst_best_sensor", best_sensor, 4'hF);
        reset = 1'b0;
        repeat (5) begin @(posedge clock); #1; end
        check("t6_no_done_after_rst", done_cnt - w0, 0);
        check("t6_queue_drained", resp_q.size(), 0);
        clear_model();
        expect_meas(0, 8'd0); expect_meas(3, 8'd5);
        do_start(6'b001001);
        wait_check("t6_restart", 1'b1);

        check("enable_single_cycle", en_double, 0);
        check("final_queue_empty", resp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
